// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the zero
// word that decode treats as a bubble, and the fetch FSM state encodings.
package stage_if_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/stage_if.sv
// Instruction fetch stage. Reads an instruction one byte at a time through a
// memory arbiter (request/grant, data one cycle after grant), assembles the
// four bytes little-endian, and presents the word to the if/id latch until it
// is accepted. A branch redirect restarts the fetch at the word-aligned target
// and discards anything in flight. rdy=0 freezes the whole stage.
//
// Handshakes:
//   mem_req_o/mem_grant_i : a request is accepted on a rising edge where both
//                           are high; the byte for it is on mem_byte_i during
//                           the following cycle.
//   inst_valid_o/inst_ready_i : the held instruction is consumed on a rising
//                           edge where both are high; while valid and not
//                           ready, pc_o and inst_o stay stable.
module stage_if
    import stage_if_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   branch_enable_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_grant_i,
    input  logic [7:0]             mem_byte_i,
    input  logic                   inst_ready_i,
    output logic                   inst_valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [2:0]             req_idx_q, req_idx_d;
    logic                   pending_q, pending_d;
    logic [1:0]             pend_idx_q, pend_idx_d;
    logic [InstBus-1:0]     inst_buf_q, inst_buf_d;
    logic                   req;

    // State register: reset wins over everything, otherwise take next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= ZeroWord;
            req_idx_q  <= 3'd0;
            pending_q  <= 1'b0;
            pend_idx_q <= 2'd0;
            inst_buf_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_idx_q  <= req_idx_d;
            pending_q  <= pending_d;
            pend_idx_q <= pend_idx_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    // Next-state logic, byte capture and memory request generation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_idx_d  = req_idx_q;
        pending_d  = pending_q;
        pend_idx_d = pend_idx_q;
        inst_buf_d = inst_buf_q;

        req        = rdy && (state_q == FETCH) && (req_idx_q < 3'd4);
        mem_req_o  = req;
        mem_addr_o = req ? (pc_q + {29'd0, req_idx_q}) : ZeroWord;

        if (rdy) begin
            // The byte for last cycle's grant lands in its little-endian slot.
            if (pending_q) begin
                inst_buf_d[{pend_idx_q, 3'b000} +: 8] = mem_byte_i;
            end

            if (branch_enable_i) begin
                // Redirect: clearing pending drops any byte still in flight.
                pc_d      = {branch_addr_i[31:2], 2'b00};
                req_idx_d = 3'd0;
                pending_d = 1'b0;
                state_d   = FETCH;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d   = FETCH;
                        req_idx_d = 3'd0;
                        pending_d = 1'b0;
                    end
                    FETCH: begin
                        if (req && mem_grant_i) begin
                            req_idx_d  = req_idx_q + 3'd1;
                            pending_d  = 1'b1;
                            pend_idx_d = req_idx_q[1:0];
                        end else begin
                            pending_d = 1'b0;
                        end
                        if (pending_q && (pend_idx_q == 2'd3)) begin
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        if (inst_ready_i) begin
                            pc_d      = pc_q + 32'd4;
                            req_idx_d = 3'd0;
                            pending_d = 1'b0;
                            state_d   = FETCH;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Instruction outputs depend only on registered state.
    always_comb begin
        inst_valid_o = (state_q == HOLD);
        pc_o         = pc_q;
        inst_o       = (state_q == HOLD) ? inst_buf_q : ZeroWord;
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for the fetch stage: a byte memory responder answers granted
// requests one cycle later; inputs change on the falling edge and outputs are
// checked there too.
module tb_stage_if;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_byte_i;
    logic        inst_ready_i;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int errors = 0;
    int checks = 0;

    stage_if dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .branch_enable_i (branch_enable_i),
        .branch_addr_i   (branch_addr_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_grant_i     (mem_grant_i),
        .mem_byte_i      (mem_byte_i),
        .inst_ready_i    (inst_ready_i),
        .inst_valid_o    (inst_valid_o),
        .pc_o            (pc_o),
        .inst_o          (inst_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory contents: addresses 0..3 hold addi a0,zero,1; others a pattern.
    function automatic logic [7:0] mem_at(input logic [31:0] a);
        case (a)
            32'd0:   mem_at = 8'h13;
            32'd1:   mem_at = 8'h05;
            32'd2:   mem_at = 8'h10;
            32'd3:   mem_at = 8'h00;
            default: mem_at = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Memory responder: data for a granted request appears the next cycle;
    // it stalls along with the rest of the pipeline when rdy is low.
    always @(posedge clk) begin
        if (rst) mem_byte_i <= 8'h00;
        else if (rdy) mem_byte_i <= (mem_req_o && mem_grant_i) ? mem_at(mem_addr_o) : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk1 ({tag, "_req"},   mem_req_o,    1'b0);
        chk32({tag, "_addr"},  mem_addr_o,   32'h0);
        chk1 ({tag, "_valid"}, inst_valid_o, 1'b0);
        chk32({tag, "_pc"},    pc_o,         32'h0);
        chk32({tag, "_inst"},  inst_o,       32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        branch_enable_i = 1'b0;
        branch_addr_i   = 32'h0;
        mem_grant_i     = 1'b1;
        inst_ready_i    = 1'b0;
        tick();
        tick();
        chk_zero_outputs("reset");

        // First fetch from address 0 with continuous grant.
        rst = 1'b0;
        tick();
        chk1 ("f0_req", mem_req_o, 1'b1);
        chk32("f0_addr0", mem_addr_o, 32'd0);
        chk32("f0_inst_bubble", inst_o, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk32("f0_addr", mem_addr_o, 32'(i));
        end
        tick();
        chk1("f0_req_done", mem_req_o, 1'b0);
        chk1("f0_not_valid_yet", inst_valid_o, 1'b0);
        tick();
        chk1 ("f0_valid", inst_valid_o, 1'b1);
        chk32("f0_inst", inst_o, 32'h00100513);
        chk32("f0_pc", pc_o, 32'h0);

        // Stall in HOLD for 3 cycles; outputs stay put.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1 ("stall_valid", inst_valid_o, 1'b1);
            chk32("stall_inst", inst_o, 32'h00100513);
            chk32("stall_pc", pc_o, 32'h0);
            chk1 ("stall_req", mem_req_o, 1'b0);
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk32("f1_addr4", mem_addr_o, 32'd4);
        chk1 ("f1_valid_drop", inst_valid_o, 1'b0);
        chk32("f1_inst_bubble", inst_o, 32'h0);
        for (int i = 5; i < 8; i++) begin
            tick();
            chk32("f1_addr", mem_addr_o, 32'(i));
        end
        tick();
        tick();
        chk1 ("f1_valid", inst_valid_o, 1'b1);
        chk32("f1_inst", inst_o, 32'hA2A3A0A1);
        chk32("f1_pc", pc_o, 32'd4);

        // Grant withheld for 2 cycles while requesting address 10.
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk32("f2_addr8", mem_addr_o, 32'd8);
        tick();
        chk32("f2_addr9", mem_addr_o, 32'd9);
        tick();
        chk32("f2_addr10", mem_addr_o, 32'd10);
        mem_grant_i = 1'b0;
        tick();
        chk32("f2_addr10_hold1", mem_addr_o, 32'd10);
        tick();
        chk32("f2_addr10_hold2", mem_addr_o, 32'd10);
        mem_grant_i = 1'b1;
        tick();
        chk32("f2_addr11", mem_addr_o, 32'd11);
        tick();
        chk1("f2_not_valid_yet", inst_valid_o, 1'b0);
        tick();
        chk1 ("f2_valid", inst_valid_o, 1'b1);
        chk32("f2_inst", inst_o, 32'hAEAFACAD);
        chk32("f2_pc", pc_o, 32'd8);

        // Redirect and accept together in HOLD: redirect wins.
        inst_ready_i    = 1'b1;
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h00002006;
        tick();
        inst_ready_i    = 1'b0;
        branch_enable_i = 1'b0;
        chk32("prio_addr", mem_addr_o, 32'h00002004);
        chk32("prio_pc", pc_o, 32'h00002004);
        chk1 ("prio_valid_drop", inst_valid_o, 1'b0);
        for (int i = 5; i < 8; i++) begin
            tick();
            chk32("prio_fetch_addr", mem_addr_o, 32'h00002000 + 32'(i));
        end
        tick();
        tick();
        chk1 ("prio_valid", inst_valid_o, 1'b1);
        chk32("prio_inst", inst_o, 32'hA2A3A0A1);
        chk32("prio_hold_pc", pc_o, 32'h00002004);

        // Redirect after two bytes; the byte for address 2 arrives stale.
        rst = 1'b1;
        tick();
        chk_zero_outputs("rst_hold");
        rst = 1'b0;
        tick();
        chk32("br_addr0", mem_addr_o, 32'd0);
        tick();
        chk32("br_addr1", mem_addr_o, 32'd1);
        tick();
        chk32("br_addr2", mem_addr_o, 32'd2);
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h00001003;
        tick();
        branch_enable_i = 1'b0;
        chk1 ("br_req", mem_req_o, 1'b1);
        chk32("br_target", mem_addr_o, 32'h00001000);
        tick();
        chk32("br_no_stale_byte", dut.inst_buf_q, 32'h00000513);
        chk32("br_addr1001", mem_addr_o, 32'h00001001);
        tick();
        chk32("br_addr1002", mem_addr_o, 32'h00001002);
        tick();
        chk32("br_addr1003", mem_addr_o, 32'h00001003);
        tick();
        tick();
        chk1 ("br_valid", inst_valid_o, 1'b1);
        chk32("br_pc", pc_o, 32'h00001000);
        chk32("br_inst", inst_o, 32'hA6A7A4A5);

        // rdy low for 4 cycles mid-fetch, with a redirect that must be ignored.
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk32("rdy_addr1004", mem_addr_o, 32'h00001004);
        tick();
        chk32("rdy_addr1005", mem_addr_o, 32'h00001005);
        rdy             = 1'b0;
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h00003000;
        #1;
        chk1("rdy_req_off", mem_req_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("rdy_stall_req", mem_req_o, 1'b0);
            chk1("rdy_stall_valid", inst_valid_o, 1'b0);
            chk32("rdy_stall_pc", pc_o, 32'h00001004);
        end
        rdy             = 1'b1;
        branch_enable_i = 1'b0;
        #1;
        chk1 ("rdy_resume_req", mem_req_o, 1'b1);
        chk32("rdy_resume_addr", mem_addr_o, 32'h00001005);
        tick();
        chk32("rdy_addr1006", mem_addr_o, 32'h00001006);
        tick();
        chk32("rdy_addr1007", mem_addr_o, 32'h00001007);
        tick();
        tick();
        chk1 ("rdy_valid", inst_valid_o, 1'b1);
        chk32("rdy_inst", inst_o, 32'hA2A3A0A1);
        chk32("rdy_pc", pc_o, 32'h00001004);

        // Reset in the middle of a fetch, then a clean fetch from 0.
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk32("mid_addr1008", mem_addr_o, 32'h00001008);
        tick();
        chk32("mid_addr1009", mem_addr_o, 32'h00001009);
        rst = 1'b1;
        tick();
        chk_zero_outputs("mid_rst");
        rst = 1'b0;
        tick();
        chk32("post_addr0", mem_addr_o, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk32("post_addr", mem_addr_o, 32'(i));
        end
        tick();
        tick();
        chk1 ("post_valid", inst_valid_o, 1'b1);
        chk32("post_inst", inst_o, 32'h00100513);
        chk32("post_pc", pc_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
